// File: rtl/regfile_wb_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler_pkg
// Shared constants and types for the register-file writeback scheduler.
//   WB_XLEN / WB_AW : default datapath width and register address width
//   REQ_ALU/REQ_LSU : requester indices used by the arbiter's last-grant pointer
//   busy_vec_t      : one busy bit per architectural register
//   reg_mask()      : one-hot register mask with x0 always excluded
// -----------------------------------------------------------------------------
package regfile_wb_scheduler_pkg;

   localparam int WB_XLEN = 32;
   localparam int WB_AW   = 5;

   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_LSU = 1'b1;

   typedef logic [(1 << WB_AW)-1:0] busy_vec_t;

   // x0 is hardwired zero, so it can never become busy.
   function automatic busy_vec_t reg_mask(input logic [WB_AW-1:0] addr);
      busy_vec_t m;
      m = '0;
      if (addr != '0) begin
         m[addr] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/regfile_wb_scheduler_wb_scoreboard.sv
// -----------------------------------------------------------------------------
// wb_scoreboard
// Busy scoreboard for in-flight destination registers plus RAW stall lookup.
// Ports:
//   clk, rst      : clock, synchronous active-low reset (clears all busy bits)
//   set_valid/addr: decode allocated a register as an in-flight destination
//   clr_valid/addr: writeback transfer for that register this cycle
//   rs1_addr/rs2_addr : decode source registers
//   stall         : combinational, rs1 or rs2 is busy
// -----------------------------------------------------------------------------
module wb_scoreboard
   import regfile_wb_scheduler_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             set_valid,
   input  logic [WB_AW-1:0] set_addr,
   input  logic             clr_valid,
   input  logic [WB_AW-1:0] clr_addr,
   input  logic [WB_AW-1:0] rs1_addr,
   input  logic [WB_AW-1:0] rs2_addr,
   output logic             stall
);

   busy_vec_t busy;
   busy_vec_t set_mask;
   busy_vec_t clr_mask;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_valid) begin
         set_mask = reg_mask(set_addr);
      end
      if (clr_valid) begin
         clr_mask = reg_mask(clr_addr);
      end
   end

   // Set is applied after clear: a new producer allocated in the same cycle
   // its predecessor writes back keeps the register busy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy <= '0;
      end else begin
         busy <= (busy & ~clr_mask) | set_mask;
      end
   end

   // Reads the registered state, so a register cleared this cycle still
   // stalls until the write actually lands on rf_wen one cycle later.
   assign stall = busy[rs1_addr] | busy[rs2_addr];

endmodule

// File: rtl/regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// regfile_wb_scheduler
// Shares the single register-file write port between the ALU (req0) and the
// LSU load return (req1), and tracks in-flight destinations for RAW stalls.
// Build option:
//   WB_ARB_ROUND_ROBIN_EN defined   : contention alternates via last-grant ptr
//   WB_ARB_ROUND_ROBIN_EN undefined : LSU always wins contention
// Ports:
//   clk, rst                       : clock, synchronous active-low reset
//   req0_valid/ready/addr/data     : ALU writeback valid/ready channel
//   req1_valid/ready/addr/data     : LSU writeback valid/ready channel
//   alloc_valid, alloc_rd          : decode issues an instruction writing rd
//   rs1_addr, rs2_addr, stall      : decode sources and RAW hazard stall
//   rf_wen, rf_waddr, rf_wdata     : registered register-file write port
// -----------------------------------------------------------------------------
module regfile_wb_scheduler
   import regfile_wb_scheduler_pkg::*;
#(
   parameter int XLEN = WB_XLEN,
   parameter int AW   = WB_AW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            req0_valid,
   output logic            req0_ready,
   input  logic [AW-1:0]   req0_addr,
   input  logic [XLEN-1:0] req0_data,
   input  logic            req1_valid,
   output logic            req1_ready,
   input  logic [AW-1:0]   req1_addr,
   input  logic [XLEN-1:0] req1_data,
   input  logic            alloc_valid,
   input  logic [AW-1:0]   alloc_rd,
   input  logic [AW-1:0]   rs1_addr,
   input  logic [AW-1:0]   rs2_addr,
   output logic            stall,
   output logic            rf_wen,
   output logic [AW-1:0]   rf_waddr,
   output logic [XLEN-1:0] rf_wdata
);

   logic            gnt0;
   logic            gnt1;
   logic            xfer;
   logic [AW-1:0]   gnt_addr;
   logic [XLEN-1:0] gnt_data;

   logic            wen_p1;
   logic [AW-1:0]   waddr_p1;
   logic [XLEN-1:0] wdata_p1;

`ifdef WB_ARB_ROUND_ROBIN_EN
   logic            last_gnt;
`endif

   // Grants are pure functions of valid; nothing is granted while in reset,
   // which also drops any request that was pending when reset arrived.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst) begin
         if (req0_valid && req1_valid) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            if (last_gnt == REQ_LSU) begin
               gnt0 = 1'b1;
            end else begin
               gnt1 = 1'b1;
            end
`else
            gnt1 = 1'b1;
`endif
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;
   assign xfer       = gnt0 | gnt1;
   assign gnt_addr   = gnt1 ? req1_addr : req0_addr;
   assign gnt_data   = gnt1 ? req1_data : req0_data;

`ifdef WB_ARB_ROUND_ROBIN_EN
   // Reset value points at the LSU so the ALU wins the first contention.
   always_ff @(posedge clk) begin
      if (!rst) begin
         last_gnt <= REQ_LSU;
      end else if (xfer) begin
         last_gnt <= gnt1 ? REQ_LSU : REQ_ALU;
      end
   end
`endif

   // ---- stage p0 -> p1: register-file write port ----
   // Writes to x0 complete the handshake but never raise the write enable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wen_p1   <= 1'b0;
         waddr_p1 <= '0;
         wdata_p1 <= '0;
      end else begin
         wen_p1 <= xfer && (gnt_addr != '0);
         if (xfer) begin
            waddr_p1 <= gnt_addr;
            wdata_p1 <= gnt_data;
         end
      end
   end

   assign rf_wen   = wen_p1;
   assign rf_waddr = waddr_p1;
   assign rf_wdata = wdata_p1;

   wb_scoreboard u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set_valid (alloc_valid),
      .set_addr  (alloc_rd),
      .clr_valid (xfer),
      .clr_addr  (gnt_addr),
      .rs1_addr  (rs1_addr),
      .rs2_addr  (rs2_addr),
      .stall     (stall)
   );

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_scheduler
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model (busy array, grant pointer, expected write next cycle).
// -----------------------------------------------------------------------------
module tb_regfile_wb_scheduler;

   logic        clk;
   logic        rst;
   logic        req0_valid;
   logic        req0_ready;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data;
   logic        req1_valid;
   logic        req1_ready;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data;
   logic        alloc_valid;
   logic [4:0]  alloc_rd;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic        stall;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;

   regfile_wb_scheduler dut (
      .clk         (clk),
      .rst         (rst),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_addr   (req0_addr),
      .req0_data   (req0_data),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_addr   (req1_addr),
      .req1_data   (req1_data),
      .alloc_valid (alloc_valid),
      .alloc_rd    (alloc_rd),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .stall       (stall),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wdata    (rf_wdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model state
   bit          busy_m [32];
   int          ptr_m;
   bit          known;
   bit          e_wen;
   bit          e_full;
   logic [4:0]  e_waddr;
   logic [31:0] e_wdata;
   bit          exp_r0;
   bit          exp_r1;

   // last observed DUT values (for scenario-specific checks)
   logic        obs_r0, obs_r1, obs_stall, obs_wen;
   logic [4:0]  obs_waddr;
   logic [31:0] obs_wdata;

   bit pend0, pend1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   // Called shortly after a negedge with inputs driven; checks the cycle,
   // advances the model across the coming posedge, returns at next negedge.
   task automatic step();
      int          win;
      bit          e_stall;
      logic [4:0]  a;
      logic [31:0] d;
      #1;
      win = -1;
      if (rst) begin
         if (req0_valid && req1_valid) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
            win = 1 - ptr_m;
`else
            win = 1;
`endif
         end else if (req0_valid) begin
            win = 0;
         end else if (req1_valid) begin
            win = 1;
         end
      end
      exp_r0 = (win == 0);
      exp_r1 = (win == 1);
      obs_r0 = req0_ready; obs_r1 = req1_ready; obs_stall = stall;
      obs_wen = rf_wen; obs_waddr = rf_waddr; obs_wdata = rf_wdata;
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, exp_r0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, exp_r1});
      if (known) begin
         e_stall = busy_m[rs1_addr] || busy_m[rs2_addr];
         chk("stall", {31'd0, stall}, {31'd0, e_stall});
         chk("rf_wen", {31'd0, rf_wen}, {31'd0, e_wen});
         if (e_wen || e_full) begin
            chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, e_waddr});
            chk("rf_wdata", rf_wdata, e_wdata);
         end
      end
      if (!rst) begin
         foreach (busy_m[k]) busy_m[k] = 1'b0;
         ptr_m = 1; e_wen = 1'b0; e_waddr = '0; e_wdata = '0;
         e_full = 1'b1; known = 1'b1;
      end else begin
         e_full = 1'b0;
         e_wen  = 1'b0;
         if (win >= 0) begin
            a = (win == 1) ? req1_addr : req0_addr;
            d = (win == 1) ? req1_data : req0_data;
            e_wen = (a != 5'd0); e_waddr = a; e_wdata = d;
            busy_m[a] = 1'b0;
            ptr_m = win;
         end
         if (alloc_valid && alloc_rd != 5'd0) busy_m[alloc_rd] = 1'b1;
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      alloc_valid = 1'b0; alloc_rd = '0; rs1_addr = '0; rs2_addr = '0;
   endtask

   initial begin
      known = 1'b0; e_wen = 1'b0; e_full = 1'b0; ptr_m = 1;
      pend0 = 1'b0; pend1 = 1'b0;
      idle_inputs();

      // reset held two cycles with both requesters valid
      rst = 1'b0;
      req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'h1111_0000;
      req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'h2222_0000;
      step();
      step();
      chk("rst_ready0", {31'd0, obs_r0}, 32'd0);
      chk("rst_ready1", {31'd0, obs_r1}, 32'd0);
      chk("rst_wen", {31'd0, obs_wen}, 32'd0);
      chk("rst_stall", {31'd0, obs_stall}, 32'd0);

      // contention: both valid four cycles, winner presents a fresh beat
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
`ifdef WB_ARB_ROUND_ROBIN_EN
         chk("cont_grant", {31'd0, obs_r1}, (i % 2 == 0) ? 32'd0 : 32'd1);
`else
         chk("cont_grant", {31'd0, obs_r1}, 32'd1);
`endif
         chk("cont_one_grant", {31'd0, obs_r0 ^ obs_r1}, 32'd1);
         if (obs_r0) req0_data = req0_data + 32'd1;
         if (obs_r1) req1_data = req1_data + 32'd1;
      end
      req1_valid = 1'b0;
      step();
      req0_valid = 1'b0;
      step();

      // single ALU request
      req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEAD_BEEF;
      step();
      chk("single_ready0", {31'd0, obs_r0}, 32'd1);
      req0_valid = 1'b0;
      step();
      chk("single_wen", {31'd0, obs_wen}, 32'd1);
      chk("single_waddr", {27'd0, obs_waddr}, 32'd5);
      chk("single_wdata", obs_wdata, 32'hDEAD_BEEF);
      step();
      chk("single_wen_drop", {31'd0, obs_wen}, 32'd0);

      // scoreboard: alloc 9, stall until after LSU writes 9
      alloc_valid = 1'b1; alloc_rd = 5'd9; rs1_addr = 5'd9;
      step();
      chk("sb_not_yet", {31'd0, obs_stall}, 32'd0);
      alloc_valid = 1'b0;
      step();
      chk("sb_busy", {31'd0, obs_stall}, 32'd1);
      req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h0000_0099;
      step();
      chk("sb_busy_xfer", {31'd0, obs_stall}, 32'd1);
      req1_valid = 1'b0;
      step();
      chk("sb_cleared", {31'd0, obs_stall}, 32'd0);
      // same-cycle alloc and writeback of 9: stays busy
      alloc_valid = 1'b1;
      step();
      req1_valid = 1'b1;
      step();
      alloc_valid = 1'b0; req1_valid = 1'b0;
      step();
      chk("sb_set_wins", {31'd0, obs_stall}, 32'd1);
      req1_valid = 1'b1;
      step();
      req1_valid = 1'b0;
      step();

      // x0 handling
      alloc_valid = 1'b1; alloc_rd = 5'd0; rs1_addr = 5'd0;
      req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'hCAFE_0000;
      step();
      chk("x0_ready0", {31'd0, obs_r0}, 32'd1);
      chk("x0_stall", {31'd0, obs_stall}, 32'd0);
      alloc_valid = 1'b0; req0_valid = 1'b0;
      step();
      chk("x0_wen", {31'd0, obs_wen}, 32'd0);
      chk("x0_stall2", {31'd0, obs_stall}, 32'd0);

      // mid-operation reset with busy[4] and a pending LSU request
      alloc_valid = 1'b1; alloc_rd = 5'd4; rs1_addr = 5'd4;
      step();
      alloc_valid = 1'b0;
      req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'h4444_4444;
      rst = 1'b0;
      step();
      chk("mrst_ready1", {31'd0, obs_r1}, 32'd0);
      rst = 1'b1; req1_valid = 1'b0;
      step();
      chk("mrst_stall", {31'd0, obs_stall}, 32'd0);
      chk("mrst_wen", {31'd0, obs_wen}, 32'd0);

      // randomized traffic with holding requesters
      idle_inputs();
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) != 0);
         if (!pend0 && $urandom_range(0, 1) == 1) begin
            pend0 = 1'b1;
            req0_addr = 5'($urandom_range(0, 7));
            req0_data = $urandom;
         end
         if (!pend1 && $urandom_range(0, 1) == 1) begin
            pend1 = 1'b1;
            req1_addr = 5'($urandom_range(0, 7));
            req1_data = $urandom;
         end
         req0_valid  = pend0;
         req1_valid  = pend1;
         alloc_valid = ($urandom_range(0, 2) == 0);
         alloc_rd    = 5'($urandom_range(0, 7));
         rs1_addr    = 5'($urandom_range(0, 7));
         rs2_addr    = 5'($urandom_range(0, 7));
         step();
         if (exp_r0 || !rst) pend0 = 1'b0;
         if (exp_r1 || !rst) pend1 = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
